alu_seq_unit: RTL and testbench

- 8-bit arithmetic/logic stage directly downstream of the register file (part2b).
- Operand A is wired from register-file O1 and operand B from O2. The result feeds back to the register file input I.
- Operands are latched on Start. Single-cycle ops complete in 1 cycle; multiply is iterative (8 cycles).
- Holds the ZCNO flag register consumed by the control unit.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_comb_core.sv | 79 +++++++
 rtl/alu_seq_unit.sv | 120 ++++++++++++
 tb/tb_alu_seq_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU stage: FunSel opcodes, FSM states, flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_PASSA = 4'b0000;
    localparam logic [3:0] OP_PASSB = 4'b0001;
    localparam logic [3:0] OP_NOTA  = 4'b0010;
    localparam logic [3:0] OP_NOTB  = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_ADC   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_OR    = 4'b1000;
    localparam logic [3:0] OP_XOR   = 4'b1001;
    localparam logic [3:0] OP_LSL   = 4'b1010;
    localparam logic [3:0] OP_LSR   = 4'b1011;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_ASR   = 4'b1101;
    localparam logic [3:0] OP_CSL   = 4'b1110;
    localparam logic [3:0] OP_CSR   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_FINISH  = 2'd2
    } state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational result and next {Z,C,N,O} for every single-cycle op; zero latency, no flow control.
// C and O pass through from c_i/o_i for ops that leave them unchanged.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       fun_sel_i,
    input  logic             c_i,
    input  logic             o_i,
    output logic [WIDTH-1:0] res_o,
    output logic [3:0]       flags_o
);

    logic [WIDTH:0] sum;
    logic           c_nxt;
    logic           o_nxt;

    always_comb begin
        sum   = '0;
        res_o = '0;
        c_nxt = c_i;
        o_nxt = o_i;
        case (fun_sel_i)
            OP_PASSA: res_o = a_i;
            OP_PASSB: res_o = b_i;
            OP_NOTA:  res_o = ~a_i;
            OP_NOTB:  res_o = ~b_i;
            OP_ADD, OP_ADC: begin
                sum   = {1'b0, a_i} + {1'b0, b_i}
                      + {{WIDTH{1'b0}}, (fun_sel_i == OP_ADC) & c_i};
                res_o = sum[WIDTH-1:0];
                c_nxt = sum[WIDTH];
                o_nxt = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            // Carry out of A + ~B + 1 is the inverted borrow.
            OP_SUB: begin
                sum   = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
                res_o = sum[WIDTH-1:0];
                c_nxt = sum[WIDTH];
                o_nxt = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:   res_o = a_i & b_i;
            OP_OR:    res_o = a_i | b_i;
            OP_XOR:   res_o = a_i ^ b_i;
            OP_LSL: begin
                res_o = {a_i[WIDTH-2:0], 1'b0};
                c_nxt = a_i[WIDTH-1];
                o_nxt = a_i[WIDTH-1] ^ a_i[WIDTH-2];
            end
            OP_LSR: begin
                res_o = {1'b0, a_i[WIDTH-1:1]};
                c_nxt = a_i[0];
            end
            OP_ASR: begin
                res_o = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
                c_nxt = a_i[0];
            end
            OP_CSL: begin
                res_o = {a_i[WIDTH-2:0], c_i};
                c_nxt = a_i[WIDTH-1];
            end
            OP_CSR: begin
                res_o = {c_i, a_i[WIDTH-1:1]};
                c_nxt = a_i[0];
            end
            default: res_o = '0;
        endcase

        flags_o         = '0;
        flags_o[FLAG_Z] = (res_o == '0);
        flags_o[FLAG_C] = c_nxt;
        flags_o[FLAG_N] = res_o[WIDTH-1];
        flags_o[FLAG_O] = o_nxt;
    end

endmodule

// File: rtl/alu_seq_unit.sv
// ALU stage with flag register: single-cycle ops complete at the Start edge, MUL takes 10 cycles.
// No queueing: Start is dropped while Busy or while the MUL result is being written.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FunSel,
    input  logic             Start,
    output logic [WIDTH-1:0] OutALU,
    output logic [WIDTH-1:0] OutHi,
    output logic [3:0]       Flags,
    output logic             Busy,
    output logic             Done
);

    localparam int             CW       = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MUL_CYCLES - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   out_q;
    logic [WIDTH-1:0]   hi_q;
    logic [3:0]         flags_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   core_res;
    logic [3:0]         core_flags;
    logic [2*WIDTH-1:0] partial_d;
    logic [3:0]         mul_flags_d;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .a_i       (A),
        .b_i       (B),
        .fun_sel_i (FunSel),
        .c_i       (flags_q[FLAG_C]),
        .o_i       (flags_q[FLAG_O]),
        .res_o     (core_res),
        .flags_o   (core_flags)
    );

    always_comb begin
        partial_d = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;

        mul_flags_d         = '0;
        mul_flags_d[FLAG_Z] = (acc_q[WIDTH-1:0] == '0);
        mul_flags_d[FLAG_C] = |acc_q[2*WIDTH-1:WIDTH];
        mul_flags_d[FLAG_N] = 1'b0;
        mul_flags_d[FLAG_O] = |acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            hi_q     <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        if (FunSel == OP_MUL) begin
                            mcand_q  <= A;
                            mplier_q <= B;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= ST_MUL_RUN;
                        end else begin
                            out_q   <= core_res;
                            hi_q    <= '0;
                            flags_q <= core_flags;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_MUL_RUN: begin
                    acc_q    <= acc_q + partial_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    out_q   <= acc_q[WIDTH-1:0];
                    hi_q    <= acc_q[2*WIDTH-1:WIDTH];
                    flags_q <= mul_flags_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign OutALU = out_q;
    assign OutHi  = hi_q;
    assign Flags  = flags_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: fixed vector table, multi-cycle corner sequences, random ops vs reference model.
module tb_alu_seq_unit;
    import alu_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] FunSel;
    logic       Start;
    logic [7:0] OutALU;
    logic [7:0] OutHi;
    logic [3:0] Flags;
    logic       Busy;
    logic       Done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] fs;
        logic [7:0] out;
        logic [7:0] hi;
        logic [3:0] fl;
    } vec_t;

    vec_t tbl [20];

    alu_seq_unit #(.WIDTH(8), .MUL_CYCLES(8)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .A      (A),
        .B      (B),
        .FunSel (FunSel),
        .Start  (Start),
        .OutALU (OutALU),
        .OutHi  (OutHi),
        .Flags  (Flags),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: integer arithmetic on the operation's meaning; returns {out, hi, Z, C, N, O}.
    function automatic logic [19:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] fs, input logic [3:0] fl);
        int ua, ub, sa, sb, r, sr, cin;
        logic c, o, n;
        logic [7:0] hi, out;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        cin = fl[FLAG_C] ? 1 : 0;
        c   = fl[FLAG_C];
        o   = fl[FLAG_O];
        hi  = 8'h00;
        r   = 0;
        sr  = 0;
        case (fs)
            OP_PASSA: r = ua;
            OP_PASSB: r = ub;
            OP_NOTA:  r = 255 - ua;
            OP_NOTB:  r = 255 - ub;
            OP_ADD: begin r = ua + ub; c = (r > 255); sr = sa + sb; o = (sr > 127) || (sr < -128); end
            OP_ADC: begin r = ua + ub + cin; c = (r > 255); sr = sa + sb + cin; o = (sr > 127) || (sr < -128); end
            OP_SUB: begin r = ua - ub; c = (ua >= ub); sr = sa - sb; o = (sr > 127) || (sr < -128); end
            OP_AND:   r = ua & ub;
            OP_OR:    r = ua | ub;
            OP_XOR:   r = ua ^ ub;
            OP_LSL: begin r = ua * 2; c = (ua >= 128); o = (ua >= 128) != ((ua % 128) >= 64); end
            OP_LSR: begin r = ua / 2; c = (ua % 2) == 1; end
            OP_MUL: begin r = ua * ub; hi = 8'(r / 256); c = (r / 256) != 0; o = c; end
            OP_ASR: begin r = ua / 2 + ((ua >= 128) ? 128 : 0); c = (ua % 2) == 1; end
            OP_CSL: begin r = ua * 2 + cin; c = (ua >= 128); end
            OP_CSR: begin r = ua / 2 + cin * 128; c = (ua % 2) == 1; end
            default: r = 0;
        endcase
        r   = r & 255;
        out = 8'(r);
        n   = (r >= 128) && (fs != OP_MUL);
        return {out, hi, (r == 0), c, n, o};
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fs,
                          input logic [7:0] e_out, input logic [7:0] e_hi, input logic [3:0] e_fl,
                          input string tag);
        int n;
        int busy_n;
        @(negedge Clock);
        A = a; B = b; FunSel = fs; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        if (fs == OP_MUL) begin
            n = 1;
            busy_n = 0;
            while (!Done && n < 30) begin
                busy_n += int'(Busy);
                @(negedge Clock);
                n++;
            end
            check({tag, "_mul_latency"}, 16'(n), 16'd10);
            check({tag, "_busy_cycles"}, 16'(busy_n), 16'd9);
        end
        check({tag, "_done"}, 16'(Done), 16'd1);
        check({tag, "_out"}, 16'(OutALU), 16'(e_out));
        check({tag, "_hi"}, 16'(OutHi), 16'(e_hi));
        check({tag, "_flags"}, 16'(Flags), 16'(e_fl));
    endtask

    initial begin
        int cyc;
        int extra_done;
        logic [3:0] m_flags;
        logic [19:0] exp;
        logic [7:0] ra, rb;
        logic [3:0] rf;

        tbl[0]  = '{8'h7F, 8'h01, OP_ADD,   8'h80, 8'h00, 4'b0011};
        tbl[1]  = '{8'h18, 8'h18, OP_SUB,   8'h00, 8'h00, 4'b1100};
        tbl[2]  = '{8'h01, 8'h01, OP_ADC,   8'h03, 8'h00, 4'b0000};
        tbl[3]  = '{8'h81, 8'h00, OP_LSL,   8'h02, 8'h00, 4'b0101};
        tbl[4]  = '{8'h02, 8'h00, OP_CSR,   8'h81, 8'h00, 4'b0011};
        tbl[5]  = '{8'h18, 8'h10, OP_MUL,   8'h80, 8'h01, 4'b0101};
        tbl[6]  = '{8'h00, 8'h00, OP_PASSA, 8'h00, 8'h00, 4'b1101};
        tbl[7]  = '{8'hFF, 8'h0F, OP_XOR,   8'hF0, 8'h00, 4'b0111};
        tbl[8]  = '{8'h81, 8'h00, OP_ASR,   8'hC0, 8'h00, 4'b0111};
        tbl[9]  = '{8'h00, 8'h01, OP_SUB,   8'hFF, 8'h00, 4'b0010};
        tbl[10] = '{8'h80, 8'h00, OP_CSL,   8'h00, 8'h00, 4'b1100};
        tbl[11] = '{8'h03, 8'h00, OP_LSR,   8'h01, 8'h00, 4'b0100};
        tbl[12] = '{8'h80, 8'h80, OP_ADD,   8'h00, 8'h00, 4'b1101};
        tbl[13] = '{8'h55, 8'h00, OP_NOTB,  8'hFF, 8'h00, 4'b0111};
        tbl[14] = '{8'h00, 8'hFF, OP_MUL,   8'h00, 8'h00, 4'b1000};
        tbl[15] = '{8'hF0, 8'h3C, OP_AND,   8'h30, 8'h00, 4'b0000};
        tbl[16] = '{8'h00, 8'h80, OP_OR,    8'h80, 8'h00, 4'b0010};
        tbl[17] = '{8'h11, 8'h7E, OP_PASSB, 8'h7E, 8'h00, 4'b0000};
        tbl[18] = '{8'h00, 8'h33, OP_NOTA,  8'hFF, 8'h00, 4'b0010};
        tbl[19] = '{8'hFF, 8'hFF, OP_MUL,   8'h01, 8'hFE, 4'b0101};

        Reset = 1'b0; Start = 1'b0; A = '0; B = '0; FunSel = '0;
        repeat (2) @(negedge Clock);
        check("rst_out", 16'(OutALU), 16'h0);
        check("rst_hi", 16'(OutHi), 16'h0);
        check("rst_flags", 16'(Flags), 16'h0);
        check("rst_busy", 16'(Busy), 16'h0);
        check("rst_done", 16'(Done), 16'h0);
        Reset = 1'b1;

        for (int i = 0; i < 20; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].fs, tbl[i].out, tbl[i].hi, tbl[i].fl,
                   $sformatf("vec%0d", i));

        // Start during MUL is dropped and operand changes do not disturb it.
        @(negedge Clock);
        A = 8'h18; B = 8'h10; FunSel = OP_MUL; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        cyc = 1;
        repeat (2) begin @(negedge Clock); cyc++; end
        A = 8'h55; B = 8'hAA; FunSel = OP_PASSA; Start = 1'b1;
        @(negedge Clock); cyc++;
        Start = 1'b0;
        while (!Done && cyc < 30) begin @(negedge Clock); cyc++; end
        check("ign_latency", 16'(cyc), 16'd10);
        check("ign_out", 16'(OutALU), 16'h80);
        check("ign_hi", 16'(OutHi), 16'h01);
        check("ign_flags", 16'(Flags), 16'b0101);
        extra_done = 0;
        repeat (3) begin @(negedge Clock); extra_done += int'(Done); end
        check("ign_no_extra_done", 16'(extra_done), 16'd0);
        check("ign_out_hold", 16'(OutALU), 16'h80);

        // Start held high: one result per cycle, Done stays asserted.
        @(negedge Clock);
        A = 8'h7F; B = 8'h01; FunSel = OP_ADD; Start = 1'b1;
        @(negedge Clock);
        check("b2b_add_out", 16'(OutALU), 16'h80);
        check("b2b_add_done", 16'(Done), 16'd1);
        A = 8'h18; B = 8'h18; FunSel = OP_SUB;
        @(negedge Clock);
        check("b2b_sub_out", 16'(OutALU), 16'h00);
        check("b2b_sub_flags", 16'(Flags), 16'b1100);
        check("b2b_sub_done", 16'(Done), 16'd1);
        A = 8'h01; B = 8'h01; FunSel = OP_ADC;
        @(negedge Clock);
        check("b2b_adc_out", 16'(OutALU), 16'h03);
        check("b2b_adc_done", 16'(Done), 16'd1);
        Start = 1'b0;
        @(negedge Clock);
        check("b2b_done_drop", 16'(Done), 16'd0);

        // Asynchronous reset in the middle of a MUL.
        A = 8'hFF; B = 8'hFF; FunSel = OP_MUL; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (3) @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        check("mrst_out", 16'(OutALU), 16'h0);
        check("mrst_hi", 16'(OutHi), 16'h0);
        check("mrst_flags", 16'(Flags), 16'h0);
        check("mrst_busy", 16'(Busy), 16'h0);
        check("mrst_done", 16'(Done), 16'h0);
        @(negedge Clock);
        Reset = 1'b1;
        extra_done = 0;
        repeat (12) begin @(negedge Clock); extra_done += int'(Done) + int'(Busy); end
        check("mrst_no_done_busy", 16'(extra_done), 16'd0);
        run_op(8'h7F, 8'h01, OP_ADD, 8'h80, 8'h00, 4'b0011, "mrst_after");

        m_flags = 4'b0011;
        for (int i = 0; i < 150; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rf  = 4'($urandom_range(0, 15));
            exp = model(ra, rb, rf, m_flags);
            run_op(ra, rb, rf, exp[19:12], exp[11:4], exp[3:0], $sformatf("rnd%0d", i));
            m_flags = exp[3:0];
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
